// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control/data bundle for the universal shift register
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             en;
    logic [2:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CNT_W-1:0] shamt;
    logic             bdir;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    // Driver side: supplies controls and data, observes the register
    modport master (
        output en, mode, sin_r, sin_l, d, start, shamt, bdir,
        input  q, sout_r, sout_l, busy, done
    );

    // Register side
    modport slave (
        input  en, mode, sin_r, sin_l, d, start, shamt, bdir,
        output q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with autonomous burst rotate
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              clrN,
    univ_shift_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROTR  = 3'b100;
    localparam logic [2:0] M_ROTL  = 3'b101;
    localparam logic [2:0] M_CLR   = 3'b110;
    localparam logic [2:0] M_HOLD2 = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic [WIDTH-1:0] q_q,     q_d;

    logic [WIDTH-1:0] rotr_w;
    logic [WIDTH-1:0] rotl_w;
    logic [WIDTH-1:0] decode_w;

    assign rotr_w = {q_q[0], q_q[WIDTH-1:1]};
    assign rotl_w = {q_q[WIDTH-2:0], q_q[WIDTH-1]};

    // Next register value selected by the per-cycle mode field
    always_comb begin
        decode_w = q_q;
        unique case (bus.mode)
            M_HOLD:  decode_w = q_q;
            M_SHR:   decode_w = {bus.sin_r, q_q[WIDTH-1:1]};
            M_SHL:   decode_w = {q_q[WIDTH-2:0], bus.sin_l};
            M_LOAD:  decode_w = bus.d;
            M_ROTR:  decode_w = rotr_w;
            M_ROTL:  decode_w = rotl_w;
            M_CLR:   decode_w = '0;
            M_HOLD2: decode_w = q_q;
            default: decode_w = q_q;
        endcase
    end

    // Burst sequencer next state; while BUSY the mode field is locked out
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        q_d     = q_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    q_d = decode_w;
                    if (bus.start) begin
                        if (bus.shamt != CNT_ZERO) begin
                            state_d = S_BUSY;
                            cnt_d   = bus.shamt;
                            dir_d   = bus.bdir;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (bus.en) begin
                    q_d   = dir_q ? rotl_w : rotr_w;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Leaves DONE even when disabled so the pulse is always one cycle
                state_d = S_IDLE;
                if (bus.en) begin
                    q_d = decode_w;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, direction and data registers with asynchronous clear
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
        end
    end

    assign bus.q      = q_q;
    assign bus.sout_r = q_q[0];
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.busy   = (state_q == S_BUSY);
    assign bus.done   = (state_q == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } sb_t;

    typedef struct {
        logic             en;
        logic [2:0]       mode;
        logic             sin_r;
        logic             sin_l;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    logic clk;
    logic clrN;
    int   checks;
    int   errors;
    sb_t  sb[$];
    vec_t vecs[13];

    univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .clrN (clrN),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_now(input string nm, input logic [WIDTH-1:0] eq, input logic eb, input logic ed);
        chk({nm, ".q"},      32'(bus.q),      32'(eq));
        chk({nm, ".busy"},   32'(bus.busy),   32'(eb));
        chk({nm, ".done"},   32'(bus.done),   32'(ed));
        chk({nm, ".sout_r"}, 32'(bus.sout_r), 32'(eq[0]));
        chk({nm, ".sout_l"}, 32'(bus.sout_l), 32'(eq[WIDTH-1]));
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input logic en_v, input logic [2:0] mode_v, input logic sr, input logic sl,
                        input logic [WIDTH-1:0] d_v, input logic st, input logic [CNT_W-1:0] sh,
                        input logic bd, input logic [WIDTH-1:0] eq, input logic eb, input logic ed,
                        input string nm);
        sb_t e;
        bus.en    = en_v;
        bus.mode  = mode_v;
        bus.sin_r = sr;
        bus.sin_l = sl;
        bus.d     = d_v;
        bus.start = st;
        bus.shamt = sh;
        bus.bdir  = bd;
        sb.push_back('{q: eq, busy: eb, done: ed});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk_now(nm, e.q, e.busy, e.done);
    endtask

    task automatic hold(input logic [WIDTH-1:0] eq, input logic eb, input logic ed, input string nm);
        step(1'b1, 3'b000, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, eq, eb, ed, nm);
    endtask

    task automatic load(input logic [WIDTH-1:0] v, input string nm);
        step(1'b1, 3'b011, 1'b0, 1'b0, v, 1'b0, '0, 1'b0, v, 1'b0, 1'b0, nm);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 3'b011, 1'b0, 1'b0, 8'h81, 8'h81};
        vecs[1]  = '{1'b1, 3'b001, 1'b1, 1'b0, 8'h00, 8'hC0};
        vecs[2]  = '{1'b1, 3'b010, 1'b0, 1'b0, 8'h00, 8'h80};
        vecs[3]  = '{1'b1, 3'b101, 1'b0, 1'b0, 8'h00, 8'h01};
        vecs[4]  = '{1'b1, 3'b100, 1'b0, 1'b0, 8'h00, 8'h80};
        vecs[5]  = '{1'b1, 3'b010, 1'b0, 1'b1, 8'h00, 8'h01};
        vecs[6]  = '{1'b1, 3'b110, 1'b0, 1'b0, 8'hFF, 8'h00};
        vecs[7]  = '{1'b1, 3'b011, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vecs[8]  = '{1'b1, 3'b111, 1'b1, 1'b1, 8'hFF, 8'h3C};
        vecs[9]  = '{1'b0, 3'b001, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[10] = '{1'b0, 3'b001, 1'b1, 1'b0, 8'h00, 8'h3C};
        vecs[11] = '{1'b0, 3'b011, 1'b1, 1'b0, 8'hFF, 8'h3C};
        vecs[12] = '{1'b1, 3'b001, 1'b0, 1'b0, 8'h00, 8'h1E};

        // Reset asserted from time zero with a start request pending
        clrN      = 1'b0;
        bus.en    = 1'b1;
        bus.mode  = 3'b011;
        bus.sin_r = 1'b0;
        bus.sin_l = 1'b0;
        bus.d     = 8'hFF;
        bus.start = 1'b1;
        bus.shamt = 4'd3;
        bus.bdir  = 1'b1;
        #1;
        chk_now("reset_initial", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_now("reset_start_ignored", 8'h00, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.mode  = 3'b000;
        clrN      = 1'b1;

        // Asynchronous clear mid-cycle
        load(8'hA5, "load_a5");
        #2 clrN = 1'b0;
        #1;
        chk_now("async_clear", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        clrN = 1'b1;
        hold(8'h00, 1'b0, 1'b0, "after_clear");

        // Mode decode and enable gating table
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l, vecs[i].d,
                 1'b0, '0, 1'b0, vecs[i].exp_q, 1'b0, 1'b0, $sformatf("vec%0d", i));
        end

        // Burst rotate left by 3; mode/d/start changes during BUSY have no effect
        load(8'h01, "b1_load");
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd3, 1, 8'h01, 1, 0, "b1_start");
        step(1, 3'b011, 1, 1, 8'hFF, 1, 4'd7, 0, 8'h02, 1, 0, "b1_rot1");
        step(1, 3'b110, 1, 1, 8'hFF, 1, 4'd7, 0, 8'h04, 1, 0, "b1_rot2");
        step(1, 3'b000, 0, 0, 8'h00, 0, 4'd0, 0, 8'h08, 0, 1, "b1_done");
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd3, 1, 8'h08, 0, 0, "b1_done_ignores_start");
        hold(8'h08, 1'b0, 1'b0, "b1_idle");

        // Burst rotate right by 9 with a two-cycle stall; wraps to rotate by 1
        load(8'h80, "b2_load");
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd9, 0, 8'h80, 1, 0, "b2_start");
        hold(8'h40, 1'b1, 1'b0, "b2_r1");
        hold(8'h20, 1'b1, 1'b0, "b2_r2");
        step(0, 3'b011, 0, 0, 8'hFF, 1, 4'd1, 1, 8'h20, 1, 0, "b2_stall1");
        step(0, 3'b011, 0, 0, 8'hFF, 1, 4'd1, 1, 8'h20, 1, 0, "b2_stall2");
        hold(8'h10, 1'b1, 1'b0, "b2_r3");
        hold(8'h08, 1'b1, 1'b0, "b2_r4");
        hold(8'h04, 1'b1, 1'b0, "b2_r5");
        hold(8'h02, 1'b1, 1'b0, "b2_r6");
        hold(8'h01, 1'b1, 1'b0, "b2_r7");
        hold(8'h80, 1'b1, 1'b0, "b2_r8");
        hold(8'h40, 1'b0, 1'b1, "b2_done");
        step(0, 3'b011, 0, 0, 8'hFF, 0, 4'd0, 0, 8'h40, 0, 0, "b2_done_exit_disabled");

        // Zero-length burst: done next cycle, q follows the mode decode
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd0, 0, 8'h40, 0, 1, "z_start_hold");
        hold(8'h40, 1'b0, 1'b0, "z_idle");
        step(1, 3'b011, 0, 0, 8'h5A, 1, 4'd0, 1, 8'h5A, 0, 1, "z_start_load");
        hold(8'h5A, 1'b0, 1'b0, "z_idle2");

        // Reset in the middle of a 5-rotate burst
        load(8'h01, "r_load");
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd5, 0, 8'h01, 1, 0, "r_start");
        hold(8'h80, 1'b1, 1'b0, "r_rot1");
        hold(8'h40, 1'b1, 1'b0, "r_rot2");
        #2 clrN = 1'b0;
        #1;
        chk_now("r_abort", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        clrN = 1'b1;
        hold(8'h00, 1'b0, 1'b0, "r_no_done1");
        hold(8'h00, 1'b0, 1'b0, "r_no_done2");
        load(8'h03, "r2_load");
        step(1, 3'b000, 0, 0, 8'h00, 1, 4'd2, 1, 8'h03, 1, 0, "r2_start");
        hold(8'h06, 1'b1, 1'b0, "r2_rot1");
        hold(8'h0C, 1'b0, 1'b1, "r2_done");
        hold(8'h0C, 1'b0, 1'b0, "r2_idle");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
